// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants and types for the NRISC data-memory path.
// Holds the default word width, wait-counter width and FSM encoding.
package nrisc_pkg;

    localparam int TAM_DEF = 16;
    localparam int WAIT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITS = 2'd1,
        DONE  = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/nrisc_dmem_array.sv
// nrisc_dmem_array: single-port synchronous RAM, TAM x 2^ADDR_W.
// Ports: clk, we (write enable), addr, wdata, rdata (registered, read-first).
module nrisc_dmem_array #(
    parameter int TAM    = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [TAM-1:0]    wdata,
    output logic [TAM-1:0]    rdata
);

    logic [TAM-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nrisc_data_mem.sv
// nrisc_data_mem: data-memory responder with wait states and ready/err.
// Ports: clk, rst (sync, active-high); CORE_DATA_load/CORE_DATA_write
// requests; CORE_DATA_ADDR, DATA_IN in; DATA_Out, DATA_ready, DATA_err out.
module nrisc_data_mem
    import nrisc_pkg::*;
#(
    parameter int TAM    = TAM_DEF,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           CORE_DATA_load,
    input  logic           CORE_DATA_write,
    input  logic [TAM-1:0] CORE_DATA_ADDR,
    input  logic [TAM-1:0] DATA_IN,
    output logic [TAM-1:0] DATA_Out,
    output logic           DATA_ready,
    output logic           DATA_err
);

    localparam logic [WAIT_W-1:0] WAIT_L = WAIT_W'(WAIT);

    dmem_state_t state, next;

    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [TAM-1:0]    lat_data;
    logic              lat_ld;
    logic              lat_wr;
    logic              lat_bad;
    logic [TAM-1:0]    dout_q;
    logic [TAM-1:0]    rdata;

    logic              req;
    logic              in_bad;
    logic              accept;
    logic              enter_done;
    logic              we;
    logic [ADDR_W-1:0] cur_addr;
    logic [TAM-1:0]    cur_data;
    logic              cur_wr;
    logic              cur_bad;

    assign req    = CORE_DATA_load | CORE_DATA_write;
    assign in_bad = (|CORE_DATA_ADDR[TAM-1:ADDR_W])
                  | (CORE_DATA_load & CORE_DATA_write);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (req) next = (WAIT_L == '0) ? DONE : WAITS;
            WAITS:   if (cnt == WAIT_W'(1)) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // With WAIT=0 the acceptance edge is also the DONE-entry edge, so the
    // RAM and write gating see the live inputs in IDLE, latched ones after.
    always_comb begin
        accept     = 1'b0;
        cur_addr   = lat_addr;
        cur_data   = lat_data;
        cur_wr     = lat_wr;
        cur_bad    = lat_bad;
        if (state == IDLE) begin
            accept   = req;
            cur_addr = CORE_DATA_ADDR[ADDR_W-1:0];
            cur_data = DATA_IN;
            cur_wr   = CORE_DATA_write;
            cur_bad  = in_bad;
        end
        enter_done = (next == DONE) && (state != DONE);
        we         = enter_done & cur_wr & ~cur_bad & ~rst;
        // The RAM read registered at DONE entry is presented during DONE;
        // dout_q captures it so the value holds until the next load.
        DATA_Out = dout_q;
        if (state == DONE && lat_ld) DATA_Out = lat_bad ? '0 : rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dout_q     <= '0;
            DATA_ready <= 1'b0;
            DATA_err   <= 1'b0;
        end else begin
            DATA_ready <= enter_done;
            DATA_err   <= enter_done & cur_bad;
            if (accept)              cnt <= WAIT_L;
            else if (state == WAITS) cnt <= cnt - WAIT_W'(1);
            if (state == DONE)       dout_q <= DATA_Out;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= CORE_DATA_ADDR[ADDR_W-1:0];
            lat_data <= DATA_IN;
            lat_ld   <= CORE_DATA_load;
            lat_wr   <= CORE_DATA_write;
            lat_bad  <= in_bad;
        end
    end

    nrisc_dmem_array #(
        .TAM    (TAM),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (cur_addr),
        .wdata (cur_data),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_nrisc_data_mem.sv
// tb_nrisc_data_mem: directed checks on three instances (WAIT = 0, 1, 3).
// Each access is driven at a negedge and observed on following negedges.
module tb_nrisc_data_mem;
    import nrisc_pkg::*;

    localparam int WT [3] = '{0, 1, 3};

    logic        clk;
    logic        rst;
    logic        ld [3];
    logic        wr [3];
    logic [15:0] ad [3];
    logic [15:0] di [3];
    logic [15:0] dq [3];
    logic        rd [3];
    logic        er [3];

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nrisc_data_mem #(.TAM(16), .ADDR_W(8), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst),
        .CORE_DATA_load(ld[0]), .CORE_DATA_write(wr[0]),
        .CORE_DATA_ADDR(ad[0]), .DATA_IN(di[0]),
        .DATA_Out(dq[0]), .DATA_ready(rd[0]), .DATA_err(er[0])
    );

    nrisc_data_mem #(.TAM(16), .ADDR_W(8), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst),
        .CORE_DATA_load(ld[1]), .CORE_DATA_write(wr[1]),
        .CORE_DATA_ADDR(ad[1]), .DATA_IN(di[1]),
        .DATA_Out(dq[1]), .DATA_ready(rd[1]), .DATA_err(er[1])
    );

    nrisc_data_mem #(.TAM(16), .ADDR_W(8), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst),
        .CORE_DATA_load(ld[2]), .CORE_DATA_write(wr[2]),
        .CORE_DATA_ADDR(ad[2]), .DATA_IN(di[2]),
        .DATA_Out(dq[2]), .DATA_ready(rd[2]), .DATA_err(er[2])
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic access(input int i, input logic l, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input bit scr, input logic e_err,
                          input bit ck_dq, input logic [15:0] e_dq,
                          input string tag);
        int hit;
        hit = 0;
        @(negedge clk);
        ld[i] = l;
        wr[i] = w;
        ad[i] = a;
        di[i] = d;
        @(posedge clk);
        for (int n = 1; n <= 20 && hit == 0; n++) begin
            @(negedge clk);
            if (n == 1 && scr) begin
                ad[i] = a ^ 16'h0001;
                di[i] = 16'hDEAD;
            end
            if (rd[i]) begin
                hit   = n;
                ld[i] = 1'b0;
                wr[i] = 1'b0;
                chk({tag, ".err"}, 32'(er[i]), 32'(e_err));
                if (ck_dq) chk({tag, ".dq"}, 32'(dq[i]), 32'(e_dq));
            end
        end
        ld[i] = 1'b0;
        wr[i] = 1'b0;
        chk({tag, ".cyc"}, hit, WT[i] + 1);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(rd[i]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld[k] = 1'b0;
            wr[k] = 1'b0;
            ad[k] = 16'h0000;
            di[k] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst.dq",  32'(dq[k]), 0);
            chk("rst.rdy", 32'(rd[k]), 0);
            chk("rst.err", 32'(er[k]), 0);
        end
        rst = 1'b0;

        // WAIT=1 store then load
        access(1, 0, 1, 16'h0012, 16'hBEEF, 0, 0, 0, 0, "st12");
        access(1, 1, 0, 16'h0012, 16'h0000, 0, 0, 1, 16'hBEEF, "ld12");

        // WAIT=0 back-to-back loads with request held
        access(0, 0, 1, 16'h0003, 16'h1111, 0, 0, 0, 0, "w0st3");
        access(0, 0, 1, 16'h0004, 16'h2222, 0, 0, 0, 0, "w0st4");
        @(negedge clk);
        ld[0] = 1'b1;
        ad[0] = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        chk("b2b.r1", 32'(rd[0]), 1);
        chk("b2b.d1", 32'(dq[0]), 32'h1111);
        ad[0] = 16'h0004;
        @(negedge clk);
        chk("b2b.gap", 32'(rd[0]), 0);
        chk("b2b.hold", 32'(dq[0]), 32'h1111);
        @(negedge clk);
        chk("b2b.r2", 32'(rd[0]), 1);
        chk("b2b.d2", 32'(dq[0]), 32'h2222);
        ld[0] = 1'b0;
        @(negedge clk);
        chk("b2b.end", 32'(rd[0]), 0);

        // illegal accesses on WAIT=1
        access(1, 0, 1, 16'h0000, 16'h0A0A, 0, 0, 0, 0, "st00");
        access(1, 1, 0, 16'h0100, 16'h0000, 0, 1, 1, 16'h0000, "ldoor");
        access(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0A0A, "ld00");
        access(1, 0, 1, 16'h0100, 16'h9999, 0, 1, 1, 16'h0A0A, "stoor");
        access(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0A0A, "ld00b");
        access(1, 1, 0, 16'h0012, 16'h0000, 0, 0, 1, 16'hBEEF, "ld12b");
        access(1, 1, 1, 16'h0000, 16'h7777, 0, 1, 1, 16'h0000, "both");
        access(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0A0A, "ld00c");

        // inputs changed during WAITS are ignored
        access(1, 0, 1, 16'h0031, 16'h5A5A, 0, 0, 0, 0, "st31");
        access(1, 0, 1, 16'h0030, 16'h4321, 1, 0, 0, 0, "st30s");
        access(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 1, 16'h4321, "ld30");
        access(1, 1, 0, 16'h0031, 16'h0000, 0, 0, 1, 16'h5A5A, "ld31");

        // WAIT=3 store aborted by reset at cycle 2
        access(2, 0, 1, 16'h0005, 16'h5555, 0, 0, 0, 0, "w3st5");
        @(negedge clk);
        wr[2] = 1'b1;
        ad[2] = 16'h0005;
        di[2] = 16'h1234;
        @(posedge clk);
        seen = 0;
        @(negedge clk);
        if (rd[2]) seen = 1;
        @(negedge clk);
        if (rd[2]) seen = 1;
        rst   = 1'b1;
        wr[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (rd[2]) seen = 1;
            @(negedge clk);
        end
        chk("abort.nordy", seen, 0);
        chk("abort.idle", 32'(u_w3.state), 32'(IDLE));
        access(2, 1, 0, 16'h0005, 16'h0000, 0, 0, 1, 16'h5555, "abort.ld");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nrisc_data_mem.md
# nrisc_data_mem

Data-memory responder for the NRISC CPU data port: accepts the core's load/store requests (`CORE_DATA_load`, `CORE_DATA_write`, `CORE_DATA_ADDR`, `DATA_IN`) and returns read data on `DATA_Out`. It contains a single-port word-addressed RAM, a programmable wait-state counter and a ready/error handshake. It sits between the CPU top and the system data bus, on the memory side of the same wires the CPU drives.

## Interface
Parameters:
- `TAM`, 16, data and address word width.
- `ADDR_W`, 8, RAM index width; depth is 2^ADDR_W words.
- `WAIT`, 1, number of wait-state cycles per access, 0..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `CORE_DATA_load`  in  1  load request, level-sensitive.
- `CORE_DATA_write`  in  1  store request, level-sensitive.
- `CORE_DATA_ADDR`  in  TAM  word address.
- `DATA_IN`  in  TAM  store data from the core.
- `DATA_Out`  out  TAM  load data to the core; registered.
- `DATA_ready`  out  1  one-cycle completion pulse.
- `DATA_err`  out  1  qualifies `DATA_ready`; the access was illegal.

## Operation
- FSM states: `IDLE`, `WAITS`, `DONE`.
- In `IDLE`, sampling `CORE_DATA_load | CORE_DATA_write` high accepts a request.
  - At acceptance, latch the address, the write data, the operation and a legality bit.
  - Load wait counter = `WAIT`.
  - Go to `WAITS`, or to `DONE` directly when `WAIT` = 0.
- In `WAITS`, decrement the counter each cycle. When it reaches 1, the next edge enters `DONE`.
- On the edge entering `DONE`:
  - Legal store: RAM[addr] <= latched data.
  - Legal load: `DATA_Out` <= RAM[addr].
  - `DATA_ready` <= 1. `DATA_err` <= illegal.
- From `DONE`, go to `IDLE` unconditionally.
- An access is illegal when any of these hold:
  - `CORE_DATA_ADDR[TAM-1:ADDR_W]` != 0 (out of range).
  - Load and write are both high at acceptance.
- Illegal accesses do not modify RAM. An illegal load drives `DATA_Out` = 0.
- `DATA_Out` holds its value until the next completed load. Stores and resets never change it except as stated under reset.
- Inputs are only sampled at acceptance. Changes to address or data during `WAITS`/`DONE` are ignored.
- Requests are level-based. A request still high when the FSM is back in `IDLE` is a new transaction. The core must deassert within the `DONE` cycle to avoid a repeat.

## Timing
- Acceptance edge = cycle 0. `DATA_ready` is high during cycle `WAIT`+1, for exactly one cycle.
- Load data is valid in the same cycle as `DATA_ready`.
- Back-to-back throughput is one access per `WAIT`+2 cycles.
- RAM write takes effect at the edge that raises `DATA_ready`. A load accepted afterwards returns the new value (no read-during-write hazard inside one transaction).
- Reset values: state `IDLE`, counter 0, `DATA_Out` = 0, `DATA_ready` = 0, `DATA_err` = 0. RAM contents are not cleared.
- Reset in `WAITS` aborts the access. No RAM write occurs and no `DATA_ready` is issued.
- Reset coinciding with the `DONE`-entry edge also aborts; reset dominates.
- Requests asserted in the cycle `rst` is high are ignored.

## Structure
- Shared package `nrisc_pkg`:
  - default `TAM`;
  - FSM state encoding (`IDLE`=0, `WAITS`=1, `DONE`=2);
  - the `WAIT` width constant (4 bits).
- Sub-module `nrisc_dmem_array`:
  - single-port synchronous RAM, `TAM` x 2^`ADDR_W`;
  - ports `clk`, `we`, `addr`, `wdata`, `rdata` (registered read).
  - The FSM sequences it so that its registered read lands on `DATA_Out` at `DONE`.
- Top file holds the FSM, the counter, the legality decode and the output registers.

## Test plan
- Reset, then `WAIT`=1: store 0xBEEF at address 0x0012. Expect `DATA_ready`=1 at cycle 2 with `DATA_err`=0. Then a load of 0x0012 gives `DATA_Out`=0xBEEF with ready at cycle 2.
- `WAIT`=0: two back-to-back loads with the request held high. Expect ready pulses 2 cycles apart and `DATA_Out` updating on each pulse.
- Load from 0x0100 with `ADDR_W`=8. Expect ready with `DATA_err`=1 and `DATA_Out`=0x0000. Next, a store to 0x0100 gives ready with `DATA_err`=1 and RAM address 0x00 unchanged.
- Load and write both high at acceptance. Expect `DATA_err`=1, no RAM change, `DATA_Out`=0.
- `WAIT`=3: store 0x1234 at 0x0005, assert `rst` at cycle 2. Expect no ready pulse, FSM in `IDLE`, and a later load of 0x0005 returning the old value.
- Change `CORE_DATA_ADDR`/`DATA_IN` during `WAITS`. Expect the latched values to be used.
